key_debounce_pulse: RTL



---
 rtl/key_debounce_pulse.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/key_debounce_pulse.sv
// Pushbutton conditioner: 2-FF synchroniser, debounce FSM, press/release strobes.
// Define KEY_REPEAT_EN to add auto-repeat press strobes while the key is held.
module key_debounce_pulse #(
  parameter int STABLE_CYCLES = 1000000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_PRESS_CHK   = 2'd1,
    ST_PRESSED     = 2'd2,
    ST_RELEASE_CHK = 2'd3
  } state_t;

  state_t        state_r, state_next_s;
  logic [CW-1:0] cnt_r, cnt_next_s;
  logic          sync1_r, key_sync_r;
  logic          key_level_r, level_next_s;
  logic          press_pulse_r, press_next_s;
  logic          release_pulse_r, release_next_s;
  logic          accept_s;
  logic          rep_pulse_s;

  // Synchroniser, FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r         <= 1'b0;
      key_sync_r      <= 1'b0;
      state_r         <= ST_RELEASED;
      cnt_r           <= '0;
      key_level_r     <= 1'b0;
      press_pulse_r   <= 1'b0;
      release_pulse_r <= 1'b0;
    end else begin
      sync1_r         <= ~key_n;
      key_sync_r      <= sync1_r;
      state_r         <= state_next_s;
      cnt_r           <= cnt_next_s;
      key_level_r     <= level_next_s;
      press_pulse_r   <= press_next_s;
      release_pulse_r <= release_next_s;
    end
  end

  // Debounce next-state: a new level must hold STABLE_CYCLES cycles in a check state.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    level_next_s   = key_level_r;
    release_next_s = 1'b0;
    accept_s       = 1'b0;
    case (state_r)
      ST_RELEASED: begin
        if (key_sync_r) begin
          state_next_s = ST_PRESS_CHK;
          cnt_next_s   = '0;
        end else begin
          state_next_s = ST_RELEASED;
        end
      end
      ST_PRESS_CHK: begin
        if (!key_sync_r) begin
          state_next_s = ST_RELEASED;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s = ST_PRESSED;
          level_next_s = 1'b1;
          accept_s     = 1'b1;
        end else begin
          cnt_next_s   = cnt_r + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!key_sync_r) begin
          state_next_s = ST_RELEASE_CHK;
          cnt_next_s   = '0;
        end else begin
          state_next_s = ST_PRESSED;
        end
      end
      ST_RELEASE_CHK: begin
        if (key_sync_r) begin
          state_next_s   = ST_PRESSED;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s   = ST_RELEASED;
          level_next_s   = 1'b0;
          release_next_s = 1'b1;
        end else begin
          cnt_next_s     = cnt_r + 1'b1;
        end
      end
      default: begin
        state_next_s = ST_RELEASED;
        cnt_next_s   = '0;
        level_next_s = 1'b0;
      end
    endcase
  end

  assign press_next_s = accept_s | rep_pulse_s;

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam int PW = $clog2(REPEAT_PERIOD + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_DELAY);
  localparam logic [PW-1:0] PER_LAST = PW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep_r, rep_next_s;
  logic [PW-1:0] per_r, per_next_s;

  // Repeat delay and period counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_r <= '0;
      per_r <= '0;
    end else begin
      rep_r <= rep_next_s;
      per_r <= per_next_s;
    end
  end

  // rep_r saturates at the delay; per_r then paces the following strobes.
  always_comb begin
    rep_next_s  = rep_r;
    per_next_s  = per_r;
    rep_pulse_s = 1'b0;
    if (accept_s) begin
      rep_next_s = '0;
      per_next_s = '0;
    end else if (state_r == ST_PRESSED) begin
      if (rep_r != REP_LAST) begin
        rep_next_s  = rep_r + 1'b1;
        rep_pulse_s = ((rep_r + 1'b1) == REP_LAST);
      end else if (per_r == PER_LAST) begin
        per_next_s  = '0;
        rep_pulse_s = 1'b1;
      end else begin
        per_next_s  = per_r + 1'b1;
      end
    end else begin
      rep_next_s = rep_r;
    end
  end
`else
  logic [63:0] unused_repeat_s;
  assign unused_repeat_s = {32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
  assign rep_pulse_s     = 1'b0;
`endif

  assign key_level     = key_level_r;
  assign press_pulse   = press_pulse_r;
  assign release_pulse = release_pulse_r;

endmodule
